noise_channel_gen: RTL and testbench



---
 rtl/noise_channel_gen.sv | 271 +++++++++++++++++++++++++++
 tb/tb_noise_channel_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_channel_gen.sv
// ============================================================================
// noise_channel_gen
// ----------------------------------------------------------------------------
// Noise voice for the APU: an XNOR LFSR clocked by a programmable frequency
// timer, gated by a volume envelope and a length counter. It consumes decoded
// register fields plus frame-sequencer tick pulses and produces an amplitude
// code for the mixer/DAC.
//
// Parameters:
//   LFSR_W     LFSR width (>= 4)
//   SHORT_TAP  bit that also takes the feedback in short mode (< LFSR_W-1)
//   VOL_W      envelope / amplitude width
//   LEN_W      length-counter load width
//   SHIFT_STOP shift values at or above this halt the LFSR
//
// Ports:
//   phi         system clock, all state on the rising edge
//   napu_reset  asynchronous active-low reset
//   tick_clk    base prescaler pulse (one phi wide)
//   tick_len    length sequencer pulse
//   tick_env    envelope sequencer pulse
//   trigger     one-cycle restart strobe
//   div_code    frequency divisor code r
//   shift       frequency shift s
//   short_mode  1 = short LFSR sequence
//   env_init    initial volume
//   env_dir     1 = envelope increases
//   env_period  envelope period, 0 = frozen
//   len_load    one-cycle length load strobe
//   len_val     length value n
//   len_en      length counting enable
//   amp         registered amplitude to the mixer
//   active      channel running
//   dac_en      DAC powered (combinational from env_init / env_dir)
//   lfsr_q      LFSR readback
//
// Build option:
//   NOISE_CH_LFSR_READBACK_EN  when defined, lfsr_q shows the live LFSR
//                              state; otherwise lfsr_q is tied to zero. The
//                              LFSR and amp behave identically either way.
// ============================================================================
module noise_channel_gen #(
    parameter int LFSR_W     = 15,
    parameter int SHORT_TAP  = 6,
    parameter int VOL_W      = 4,
    parameter int LEN_W      = 6,
    parameter int SHIFT_STOP = 14
) (
    input  logic              phi,
    input  logic              napu_reset,
    input  logic              tick_clk,
    input  logic              tick_len,
    input  logic              tick_env,
    input  logic              trigger,
    input  logic [2:0]        div_code,
    input  logic [3:0]        shift,
    input  logic              short_mode,
    input  logic [VOL_W-1:0]  env_init,
    input  logic              env_dir,
    input  logic [2:0]        env_period,
    input  logic              len_load,
    input  logic [LEN_W-1:0]  len_val,
    input  logic              len_en,
    output logic [VOL_W-1:0]  amp,
    output logic              active,
    output logic              dac_en,
    output logic [LFSR_W-1:0] lfsr_q
);

    // The timer must hold the largest period minus one: 14 << (SHIFT_STOP-1).
    localparam int CNT_W = 4 + SHIFT_STOP - 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LFSR_W-1:0] LFSR_ZERO = {LFSR_W{1'b0}};
    localparam logic [VOL_W-1:0]  VOL_ZERO  = {VOL_W{1'b0}};
    localparam logic [VOL_W-1:0]  VOL_ONE   = {{(VOL_W-1){1'b0}}, 1'b1};
    localparam logic [VOL_W-1:0]  VOL_MAX   = {VOL_W{1'b1}};
    localparam logic [LEN_W:0]    LEN_ZERO  = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0]    LEN_ONE   = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0]    LEN_FULL  = {1'b1, {LEN_W{1'b0}}};

    // State registers
    logic [CNT_W-1:0]  timer_r;
    logic [LFSR_W-1:0] lfsr_r;
    logic [VOL_W-1:0]  vol_r;
    logic [2:0]        env_cnt_r;
    logic              env_done_r;
    logic [LEN_W:0]    len_cnt_r;
    logic              active_r;
    logic [VOL_W-1:0]  amp_r;

    // Next-state and helper signals
    logic [3:0]        div_base_s;
    logic [CNT_W-1:0]  reload_s;
    logic              timer_halt_s;
    logic [CNT_W-1:0]  timer_nxt_s;
    logic              lfsr_step_en_s;
    logic              lfsr_fb_s;
    logic [LFSR_W-1:0] lfsr_step_s;
    logic [LFSR_W-1:0] lfsr_nxt_s;
    logic [VOL_W-1:0]  vol_nxt_s;
    logic [2:0]        env_cnt_nxt_s;
    logic              env_done_nxt_s;
    logic [LEN_W:0]    len_cnt_nxt_s;
    logic              len_expire_s;
    logic              active_nxt_s;
    logic [VOL_W-1:0]  amp_nxt_s;

    assign dac_en = (env_init != VOL_ZERO) || env_dir;

    // Timer reload value P-1, where P = (r==0 ? 1 : 2r) << s.
    always_comb begin
        if (div_code == 3'd0) begin
            div_base_s = 4'd1;
        end else begin
            div_base_s = {div_code, 1'b0};
        end
        reload_s     = (CNT_W'(div_base_s) << shift) - CNT_ONE;
        timer_halt_s = (int'(shift) >= SHIFT_STOP);
    end

    // Frequency timer: counts tick_clk pulses down and flags an LFSR step on
    // expiry. Trigger reloads and swallows a coincident tick.
    always_comb begin
        timer_nxt_s    = timer_r;
        lfsr_step_en_s = 1'b0;
        if (trigger) begin
            timer_nxt_s = reload_s;
        end else if (tick_clk && !timer_halt_s) begin
            if (timer_r == CNT_ZERO) begin
                timer_nxt_s    = reload_s;
                lfsr_step_en_s = 1'b1;
            end else begin
                timer_nxt_s = timer_r - CNT_ONE;
            end
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // XNOR LFSR next state; short mode also drops the feedback into SHORT_TAP,
    // which shortens the cycle to the bits at and below that tap.
    always_comb begin
        lfsr_fb_s   = ~(lfsr_r[0] ^ lfsr_r[1]);
        lfsr_step_s = {lfsr_fb_s, lfsr_r[LFSR_W-1:1]};
        if (short_mode) begin
            lfsr_step_s[SHORT_TAP] = lfsr_fb_s;
        end else begin
            lfsr_step_s[SHORT_TAP] = lfsr_r[SHORT_TAP+1];
        end

        if (trigger) begin
            lfsr_nxt_s = LFSR_ZERO;
        end else if (lfsr_step_en_s) begin
            lfsr_nxt_s = lfsr_step_s;
        end else begin
            lfsr_nxt_s = lfsr_r;
        end
    end

    // Volume envelope: divides tick_env by env_period and steps vol by one,
    // latching env_done instead of wrapping past either end of the range.
    always_comb begin
        vol_nxt_s      = vol_r;
        env_cnt_nxt_s  = env_cnt_r;
        env_done_nxt_s = env_done_r;
        if (trigger) begin
            vol_nxt_s      = env_init;
            env_cnt_nxt_s  = env_period;
            env_done_nxt_s = 1'b0;
        end else if (tick_env && (env_period != 3'd0) && !env_done_r) begin
            // A counter at 0 (period raised from 0 mid-run) expires at once.
            if (env_cnt_r <= 3'd1) begin
                env_cnt_nxt_s = env_period;
                if (env_dir) begin
                    if (vol_r == VOL_MAX) begin
                        env_done_nxt_s = 1'b1;
                    end else begin
                        vol_nxt_s = vol_r + VOL_ONE;
                    end
                end else begin
                    if (vol_r == VOL_ZERO) begin
                        env_done_nxt_s = 1'b1;
                    end else begin
                        vol_nxt_s = vol_r - VOL_ONE;
                    end
                end
            end else begin
                env_cnt_nxt_s = env_cnt_r - 3'd1;
            end
        end else begin
            vol_nxt_s = vol_r;
        end
    end

    // Length counter. A load always yields a non-zero count, so a trigger in
    // the same cycle never needs the full-length reload.
    always_comb begin
        len_cnt_nxt_s = len_cnt_r;
        len_expire_s  = 1'b0;
        if (len_load) begin
            len_cnt_nxt_s = LEN_FULL - {1'b0, len_val};
        end else if (trigger) begin
            if (len_cnt_r == LEN_ZERO) begin
                len_cnt_nxt_s = LEN_FULL;
            end else begin
                len_cnt_nxt_s = len_cnt_r;
            end
        end else if (tick_len && len_en && active_r && (len_cnt_r != LEN_ZERO)) begin
            len_cnt_nxt_s = len_cnt_r - LEN_ONE;
            len_expire_s  = (len_cnt_r == LEN_ONE);
        end else begin
            len_cnt_nxt_s = len_cnt_r;
        end
    end

    // Channel enable and the amplitude that goes with the next state, so that
    // a trigger or LFSR step shows up on amp in the same phi as on lfsr_q.
    always_comb begin
        active_nxt_s = active_r;
        if (trigger && dac_en) begin
            active_nxt_s = 1'b1;
        end else if (!dac_en) begin
            active_nxt_s = 1'b0;
        end else if (len_expire_s) begin
            active_nxt_s = 1'b0;
        end else begin
            active_nxt_s = active_r;
        end

        if (active_nxt_s && !lfsr_nxt_s[0]) begin
            amp_nxt_s = vol_nxt_s;
        end else begin
            amp_nxt_s = VOL_ZERO;
        end
    end

    // State register bank.
    always_ff @(posedge phi or negedge napu_reset) begin
        if (!napu_reset) begin
            timer_r    <= CNT_ZERO;
            lfsr_r     <= LFSR_ZERO;
            vol_r      <= VOL_ZERO;
            env_cnt_r  <= 3'd0;
            env_done_r <= 1'b0;
            len_cnt_r  <= LEN_ZERO;
            active_r   <= 1'b0;
            amp_r      <= VOL_ZERO;
        end else begin
            timer_r    <= timer_nxt_s;
            lfsr_r     <= lfsr_nxt_s;
            vol_r      <= vol_nxt_s;
            env_cnt_r  <= env_cnt_nxt_s;
            env_done_r <= env_done_nxt_s;
            len_cnt_r  <= len_cnt_nxt_s;
            active_r   <= active_nxt_s;
            amp_r      <= amp_nxt_s;
        end
    end

    assign amp    = amp_r;
    assign active = active_r;

`ifdef NOISE_CH_LFSR_READBACK_EN
    assign lfsr_q = lfsr_r;
`else
    assign lfsr_q = LFSR_ZERO;
`endif

endmodule

// File: tb/tb_noise_channel_gen.sv
// ============================================================================
// tb_noise_channel_gen
// Directed self-checking bench for noise_channel_gen (default parameters).
// Inputs change 1 time unit after a rising phi edge; outputs are sampled at
// the same offset, i.e. they show the result of the preceding edge.
// ============================================================================
module tb_noise_channel_gen;

    logic        phi = 1'b0;
    logic        napu_reset;
    logic        tick_clk, tick_len, tick_env, trigger;
    logic [2:0]  div_code;
    logic [3:0]  shift;
    logic        short_mode;
    logic [3:0]  env_init;
    logic        env_dir;
    logic [2:0]  env_period;
    logic        len_load;
    logic [5:0]  len_val;
    logic        len_en;
    logic [3:0]  amp;
    logic        active;
    logic        dac_en;
    logic [14:0] lfsr_q;

    int checks   = 0;
    int failures = 0;

    logic [14:0] first_steps [3] = '{15'h4000, 15'h6000, 15'h7000};

    noise_channel_gen dut (
        .phi        (phi),
        .napu_reset (napu_reset),
        .tick_clk   (tick_clk),
        .tick_len   (tick_len),
        .tick_env   (tick_env),
        .trigger    (trigger),
        .div_code   (div_code),
        .shift      (shift),
        .short_mode (short_mode),
        .env_init   (env_init),
        .env_dir    (env_dir),
        .env_period (env_period),
        .len_load   (len_load),
        .len_val    (len_val),
        .len_en     (len_en),
        .amp        (amp),
        .active     (active),
        .dac_en     (dac_en),
        .lfsr_q     (lfsr_q)
    );

    always #5 phi = ~phi;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge phi);
        #1;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    task automatic pulse_env();
        tick_env = 1'b1;
        cyc(1);
        tick_env = 1'b0;
    endtask

    task automatic pulse_len();
        tick_len = 1'b1;
        cyc(1);
        tick_len = 1'b0;
    endtask

    // Reference LFSR step taken straight from the channel description.
    function automatic logic [14:0] lfsr_next(input logic [14:0] q, input logic sm);
        logic        fb;
        logic [14:0] n;
        fb = ~(q[0] ^ q[1]);
        n  = {fb, q[14:1]};
        if (sm) n[6] = fb;
        return n;
    endfunction

    // Readback is only live when the option is built in.
    function automatic logic [14:0] exp_q(input logic [14:0] v);
`ifdef NOISE_CH_LFSR_READBACK_EN
        return v;
`else
        return 15'h0000 & v;
`endif
    endfunction

    function automatic logic [3:0] exp_amp(input logic [14:0] q, input logic [3:0] v);
        return q[0] ? 4'h0 : v;
    endfunction

    initial begin
        logic [14:0] mq;
        int          errs;

        napu_reset = 1'b0;
        tick_clk = 1'b0; tick_len = 1'b0; tick_env = 1'b0; trigger = 1'b0;
        div_code = 3'd0; shift = 4'd0; short_mode = 1'b0;
        env_init = 4'h0; env_dir = 1'b0; env_period = 3'd0;
        len_load = 1'b0; len_val = 6'd0; len_en = 1'b0;

        #12;
        check_val("rst_amp",    32'(amp),    32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        check_val("rst_lfsr",   32'(lfsr_q), 32'h0);
        check_val("rst_dac_en", 32'(dac_en), 32'h0);
        cyc(1);
        napu_reset = 1'b1;
        cyc(1);

        // Long sequence, fastest timer
        env_init = 4'hF;
        #1;
        check_val("dac_en_on", 32'(dac_en), 32'h1);
        pulse_trigger();
        check_val("trig_active", 32'(active), 32'h1);
        check_val("trig_amp",    32'(amp),    32'hF);
        check_val("trig_lfsr",   32'(lfsr_q), 32'h0);
        tick_clk = 1'b1;
        mq = 15'h0000;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            mq = lfsr_next(mq, 1'b0);
            check_val($sformatf("lfsr_step%0d", i + 1), 32'(lfsr_q), 32'(exp_q(first_steps[i])));
            check_val($sformatf("amp_step%0d", i + 1),  32'(amp),    32'hF);
        end
        errs = 0;
        for (int i = 3; i < 40; i++) begin
            cyc(1);
            mq = lfsr_next(mq, 1'b0);
            if (amp !== exp_amp(mq, 4'hF) || lfsr_q !== exp_q(mq)) errs++;
        end
        check_val("long_seq_errs", 32'(errs), 32'h0);
        tick_clk = 1'b0;

        // Short sequence over two full 127-step periods
        short_mode = 1'b1;
        pulse_trigger();
        tick_clk = 1'b1;
        cyc(1);
        check_val("short_step1_lfsr", 32'(lfsr_q), 32'(exp_q(15'h4040)));
        check_val("short_step1_amp",  32'(amp),    32'hF);
        mq = 15'h4040;
        errs = 0;
        for (int i = 0; i < 260; i++) begin
            cyc(1);
            mq = lfsr_next(mq, 1'b1);
            if (amp !== exp_amp(mq, 4'hF) || lfsr_q !== exp_q(mq)) errs++;
        end
        check_val("short_seq_errs", 32'(errs), 32'h0);
        tick_clk = 1'b0;
        short_mode = 1'b0;

        // r=1, s=1 gives P=4: step 15 (first q[0]=1) lands on tick 60
        div_code = 3'd1;
        shift = 4'd1;
        pulse_trigger();
        tick_clk = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            cyc(1);
            if (t == 3)  check_val("p4_tick3_lfsr", 32'(lfsr_q), 32'(exp_q(15'h0000)));
            if (t == 4)  check_val("p4_tick4_lfsr", 32'(lfsr_q), 32'(exp_q(15'h4000)));
            if (t == 59) check_val("p4_tick59_amp", 32'(amp), 32'hF);
            if (t == 60) check_val("p4_tick60_amp", 32'(amp), 32'h0);
        end
        tick_clk = 1'b0;
        div_code = 3'd0;
        shift = 4'd0;

        // Envelope decreasing to 0, then held by env_done
        env_init = 4'h2; env_dir = 1'b0; env_period = 3'd1;
        pulse_trigger();
        check_val("envd_init", 32'(amp), 32'h2);
        pulse_env();
        check_val("envd_tick1", 32'(amp), 32'h1);
        pulse_env();
        check_val("envd_tick2", 32'(amp), 32'h0);
        pulse_env();
        check_val("envd_tick3", 32'(amp), 32'h0);
        check_val("envd_active", 32'(active), 32'h1);
        env_dir = 1'b1;
        pulse_env();
        check_val("envd_done_hold", 32'(amp), 32'h0);
        env_dir = 1'b0;

        // Envelope increasing, saturating at 0xF
        env_init = 4'hE; env_dir = 1'b1; env_period = 3'd1;
        pulse_trigger();
        check_val("envu_init", 32'(amp), 32'hE);
        pulse_env();
        check_val("envu_tick1", 32'(amp), 32'hF);
        pulse_env();
        check_val("envu_tick2", 32'(amp), 32'hF);

        // Period 2: one step per two ticks
        env_init = 4'h5; env_dir = 1'b0; env_period = 3'd2;
        pulse_trigger();
        pulse_env();
        check_val("env_p2_tick1", 32'(amp), 32'h5);
        pulse_env();
        check_val("env_p2_tick2", 32'(amp), 32'h4);

        // Period 0: frozen
        env_period = 3'd0;
        pulse_trigger();
        pulse_env();
        check_val("env_frozen", 32'(amp), 32'h5);

        // Length counter: n=62 leaves 2 ticks
        env_init = 4'hF; env_dir = 1'b0; env_period = 3'd0;
        len_val = 6'd62; len_en = 1'b1;
        len_load = 1'b1;
        cyc(1);
        len_load = 1'b0;
        pulse_trigger();
        check_val("len_trig_active", 32'(active), 32'h1);
        pulse_len();
        check_val("len_tick1", 32'(active), 32'h1);
        pulse_len();
        check_val("len_expire",     32'(active), 32'h0);
        check_val("len_expire_amp", 32'(amp),    32'h0);
        pulse_trigger();
        check_val("len_reload_active", 32'(active), 32'h1);
        pulse_len();
        check_val("len_reload_tick", 32'(active), 32'h1);
        // n=63 leaves one tick; a coincident trigger swallows the tick
        len_val = 6'd63;
        len_load = 1'b1;
        cyc(1);
        len_load = 1'b0;
        trigger = 1'b1; tick_len = 1'b1;
        cyc(1);
        trigger = 1'b0; tick_len = 1'b0;
        check_val("trig_beats_tick", 32'(active), 32'h1);
        pulse_len();
        check_val("len_one_expire", 32'(active), 32'h0);
        len_en = 1'b0;

        // Shift at the stop value: LFSR never steps
        shift = 4'd14;
        pulse_trigger();
        tick_clk = 1'b1;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (amp !== 4'hF || lfsr_q !== 15'h0000) errs++;
        end
        check_val("halt_errs", 32'(errs), 32'h0);
        tick_clk = 1'b0;
        shift = 4'd0;

        // DAC power-down while active
        check_val("pre_dac_off_active", 32'(active), 32'h1);
        env_init = 4'h0; env_dir = 1'b0;
        #1;
        check_val("dac_en_off",       32'(dac_en), 32'h0);
        check_val("active_before_edge", 32'(active), 32'h1);
        cyc(1);
        check_val("dac_off_active", 32'(active), 32'h0);
        check_val("dac_off_amp",    32'(amp),    32'h0);
        pulse_trigger();
        check_val("trig_dac_off", 32'(active), 32'h0);

        // Asynchronous reset mid-run
        env_init = 4'hF;
        pulse_trigger();
        tick_clk = 1'b1;
        cyc(2);
        check_val("pre_rst_amp", 32'(amp), 32'hF);
        #2;
        napu_reset = 1'b0;
        #1;
        check_val("async_rst_amp",    32'(amp),    32'h0);
        check_val("async_rst_active", 32'(active), 32'h0);
        check_val("async_rst_lfsr",   32'(lfsr_q), 32'h0);
        tick_clk = 1'b0;
        cyc(1);
        napu_reset = 1'b1;
        cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
